// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, the IF/ID pipeline register, and a
// three-state handshake with instruction memory (fetch, held-on-stall, discard-on-redirect).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic [5:0]  opcode
);

    typedef enum logic [1:0] {StFetch, StHeld, StDiscard} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;

    logic        redirect;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign redirect      = ifid_valid_q & (jump | (branch & zero));
    assign jump_target   = {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00};
    assign branch_target = ifid_pc4_q + {{14{ifid_instr_q[15]}}, ifid_instr_q[15:0], 2'b00};
    assign target        = jump ? jump_target : branch_target;
    assign pc_plus4      = pc_q + 32'd4;

    assign imem_req   = (state_q != StHeld);
    assign imem_addr  = pc_q;
    assign ifid_valid = ifid_valid_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign opcode     = ifid_instr_q[31:26];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;

        unique case (state_q)
            StFetch: begin
                if (imem_ready) begin
                    if (redirect) begin
                        pc_d         = target;
                        ifid_valid_d = 1'b0;
                        ifid_instr_d = '0;
                    end else if (!stall) begin
                        ifid_instr_d = imem_rdata;
                        ifid_pc4_d   = pc_plus4;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_plus4;
                    end else begin
                        // Park the returned word until decode frees the IF/ID register.
                        hold_instr_d = imem_rdata;
                        hold_pc4_d   = pc_plus4;
                        pc_d         = pc_plus4;
                        state_d      = StHeld;
                    end
                end else if (redirect) begin
                    // Request already issued must complete before the new address goes out.
                    pend_pc_d    = target;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = '0;
                    state_d      = StDiscard;
                end else if (!stall) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = '0;
                end
            end
            StHeld: begin
                if (redirect) begin
                    pc_d         = target;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = '0;
                    state_d      = StFetch;
                end else if (!stall) begin
                    ifid_instr_d = hold_instr_q;
                    ifid_pc4_d   = hold_pc4_q;
                    ifid_valid_d = 1'b1;
                    state_d      = StFetch;
                end
            end
            StDiscard: begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = '0;
                if (redirect) begin
                    pend_pc_d = target;
                end
                if (imem_ready) begin
                    pc_d    = redirect ? target : pend_pc_q;
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            hold_instr_q <= '0;
            hold_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table for streaming/stall/bubble behaviour plus
// hand-written sequences for jump, branch, discard and reset during discard.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branch, zero, jump;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic [5:0]  opcode;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .branch     (branch),
        .zero       (zero),
        .jump       (jump),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .opcode     (opcode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        ready;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [31:0] dw(input logic [31:0] a);
        return 32'hA5A5_0000 | a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic valid, input logic [31:0] instr, input logic [31:0] pc4);
        logic [31:0] ei;
        ei = instr;
        chk({tag, ".req"},    {31'd0, imem_req},   {31'd0, req});
        chk({tag, ".addr"},   imem_addr,           addr);
        chk({tag, ".valid"},  {31'd0, ifid_valid}, {31'd0, valid});
        chk({tag, ".instr"},  ifid_instr,          instr);
        chk({tag, ".pc4"},    ifid_pc4,            pc4);
        chk({tag, ".opcode"}, {26'd0, opcode},     {26'd0, ei[31:26]});
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic s, input logic b, input logic z, input logic j,
                         input logic r, input logic [31:0] d);
        @(negedge clk);
        stall = s; branch = b; zero = z; jump = j; imem_ready = r; imem_rdata = d;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 0; branch = 0; zero = 0; jump = 0; imem_ready = 0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        chk_out("reset", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        //           stall ready rdata     req  addr   valid instr     pc4
        vecs[0] = '{1'b0, 1'b1, dw(32'h0), 1'b1, 32'h0, 1'b0, 32'h0,     32'h0};
        vecs[1] = '{1'b0, 1'b1, dw(32'h4), 1'b1, 32'h4, 1'b1, dw(32'h0), 32'h4};
        vecs[2] = '{1'b1, 1'b1, dw(32'h8), 1'b1, 32'h8, 1'b1, dw(32'h4), 32'h8};
        vecs[3] = '{1'b1, 1'b0, 32'h0,     1'b0, 32'hC, 1'b1, dw(32'h4), 32'h8};
        vecs[4] = '{1'b0, 1'b0, 32'h0,     1'b0, 32'hC, 1'b1, dw(32'h4), 32'h8};
        vecs[5] = '{1'b0, 1'b1, dw(32'hC), 1'b1, 32'hC, 1'b1, dw(32'h8), 32'hC};
        vecs[6] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h10, 1'b1, dw(32'hC), 32'h10};
        vecs[7] = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h10, 1'b0, 32'h0,   32'h10};
        vecs[8] = '{1'b0, 1'b1, dw(32'h10), 1'b1, 32'h10, 1'b0, 32'h0,  32'h10};
        vecs[9] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h14, 1'b1, dw(32'h10), 32'h14};

        // Streaming, stall into HELD, release, bubble and stalled bubble.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].stall, 1'b0, 1'b0, 1'b0, vecs[i].ready, vecs[i].rdata);
            chk_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                    vecs[i].instr, vecs[i].pc4);
        end

        // Jump from pc4=0x4 with instr 0x0800_0010 lands on 0x40.
        do_reset();
        drive(0, 0, 0, 0, 1, 32'h0800_0010);
        chk_out("jmp0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        drive(0, 0, 0, 1, 1, 32'hFFFF_FFFF);
        chk_out("jmp1", 1'b1, 32'h4, 1'b1, 32'h0800_0010, 32'h4);
        drive(0, 0, 0, 0, 0, 32'h0);
        chk_out("jmp2", 1'b1, 32'h40, 1'b0, 32'h0, 32'h4);

        // Branch taken: offset 0xFFFE from pc4 0x20 -> 0x18.
        do_reset();
        for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 1, 32'h0);
        drive(0, 0, 0, 0, 1, 32'h1000_FFFE);
        drive(0, 1, 1, 0, 1, 32'h1234_5678);
        chk_out("beq_t0", 1'b1, 32'h20, 1'b1, 32'h1000_FFFE, 32'h20);
        drive(0, 0, 0, 0, 0, 32'h0);
        chk_out("beq_t1", 1'b1, 32'h18, 1'b0, 32'h0, 32'h20);

        // Branch not taken: sequential fetch continues to 0x24.
        do_reset();
        for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 1, 32'h0);
        drive(0, 0, 0, 0, 1, 32'h1000_FFFE);
        drive(0, 1, 0, 0, 1, 32'h1234_5678);
        drive(0, 0, 0, 0, 0, 32'h0);
        chk_out("beq_n", 1'b1, 32'h24, 1'b1, 32'h1234_5678, 32'h24);

        // Discard: jump to 0x100 while the request for 0x10 is outstanding.
        do_reset();
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 32'h0);
        drive(0, 0, 0, 0, 1, 32'h0800_0040);
        drive(0, 0, 0, 1, 0, 32'h0);
        chk_out("dis0", 1'b1, 32'h10, 1'b1, 32'h0800_0040, 32'h10);
        drive(0, 0, 0, 0, 0, 32'h0);
        chk_out("dis1", 1'b1, 32'h10, 1'b0, 32'h0, 32'h10);
        drive(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk_out("dis2", 1'b1, 32'h10, 1'b0, 32'h0, 32'h10);
        drive(0, 0, 0, 0, 0, 32'h0);
        chk_out("dis3", 1'b1, 32'h100, 1'b0, 32'h0, 32'h10);

        // Reset pulsed mid-DISCARD takes effect without a clock edge.
        do_reset();
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 32'h0);
        drive(0, 0, 0, 0, 1, 32'h0800_0040);
        drive(0, 0, 0, 1, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0);
        chk_out("rd0", 1'b1, 32'h10, 1'b0, 32'h0, 32'h10);
        #2;
        rst = 1'b1;
        #1;
        chk_out("rd1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 32'h2222_3333);
        chk_out("rd2", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0);
        chk_out("rd3", 1'b1, 32'h4, 1'b1, 32'h2222_3333, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
